// File: rtl/counter_pkg.sv
// Shared constants for the loadable counter: default widths and the reset count value.
package counter_pkg;

    localparam int          DEFAULT_ADDRESS_WIDTH = 16;
    localparam int          DEFAULT_DATA_WIDTH    = 16;
    localparam int unsigned RESET_COUNT           = 0;

endpackage : counter_pkg

// File: rtl/counter_w_load_if.sv
// Load/count control and count/wrap status bundle for counter_w_load.
// The master drives the strobes and load value; the slave (the counter) returns data and wrap.
interface counter_w_load_if
    import counter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) ();

    logic                     load;
    logic                     enable;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
    logic                     wrap;

    modport master (
        output load,
        output enable,
        output address,
        input  data,
        input  wrap
    );

    modport slave (
        input  load,
        input  enable,
        input  address,
        output data,
        output wrap
    );

endinterface : counter_w_load_if

// File: rtl/counter_w_load.sv
// Up-counter with active-low parallel load (priority over enable) and a registered wrap pulse.
// Latency: load/increment visible right after the edge; no backpressure, enable is the only throttle.
module counter_w_load
    import counter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic                     enable,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     wrap
);

    logic [DATA_WIDTH-1:0] load_value;

    // Narrow the load value to the count width: truncate when wider, zero-extend when narrower.
    generate
        if (ADDRESS_WIDTH > DATA_WIDTH) begin : g_truncate
            logic unused_address_hi;
            assign unused_address_hi = ^address[ADDRESS_WIDTH-1:DATA_WIDTH];
            assign load_value        = address[DATA_WIDTH-1:0];
        end else if (ADDRESS_WIDTH == DATA_WIDTH) begin : g_direct
            assign load_value = address;
        end else begin : g_extend
            assign load_value = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, address};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data <= DATA_WIDTH'(RESET_COUNT);
            wrap <= 1'b0;
        end else if (!load) begin
            // A load never reports a wrap, even when the loaded value is zero.
            data <= load_value;
            wrap <= 1'b0;
        end else if (enable) begin
            data <= data + DATA_WIDTH'(1);
            wrap <= &data;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule : counter_w_load

// File: tb/tb_counter_w_load.sv
// Directed self-checking bench: a 16/16 counter and a 16/8 width-mismatch counter.
module tb_counter_w_load;

    logic clock;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    counter_w_load_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) bus16 ();
    counter_w_load_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8))  bus8  ();

    counter_w_load #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (bus16.load),
        .enable  (bus16.enable),
        .address (bus16.address),
        .data    (bus16.data),
        .wrap    (bus16.wrap)
    );

    counter_w_load #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (bus8.load),
        .enable  (bus8.enable),
        .address (bus8.address),
        .data    (bus8.data),
        .wrap    (bus8.wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset asserted with load inactive and enable active: outputs cleared without any edge.
        reset_n        = 1'b0;
        bus16.load     = 1'b1;
        bus16.enable   = 1'b1;
        bus16.address  = 16'h0000;
        bus8.load      = 1'b1;
        bus8.enable    = 1'b0;
        bus8.address   = 16'h0000;
        #2;
        check("reset_data16", 32'(bus16.data), 32'h0);
        check("reset_wrap16", 32'(bus16.wrap), 32'h0);
        check("reset_data8",  32'(bus8.data),  32'h0);

        bus16.enable = 1'b0;
        #1 reset_n = 1'b1;
        step();
        check("hold_after_reset", 32'(bus16.data), 32'h0);

        // Load 55, then count three edges.
        bus16.address = 16'd55;
        bus16.load    = 1'b0;
        step();
        check("load_55", 32'(bus16.data), 32'd55);
        check("load_55_wrap", 32'(bus16.wrap), 32'h0);
        bus16.load   = 1'b1;
        bus16.enable = 1'b1;
        step();
        check("count_56", 32'(bus16.data), 32'd56);
        step();
        check("count_57", 32'(bus16.data), 32'd57);
        step();
        check("count_58", 32'(bus16.data), 32'd58);
        check("count_58_wrap", 32'(bus16.wrap), 32'h0);

        // Hold for three edges.
        bus16.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_58", 32'(bus16.data), 32'd58);
        end

        // Load wins over enable.
        bus16.load    = 1'b0;
        bus16.enable  = 1'b1;
        bus16.address = 16'd7;
        step();
        check("priority_load_7", 32'(bus16.data), 32'd7);

        // Wrap from 0xFFFF.
        bus16.address = 16'hFFFF;
        bus16.enable  = 1'b0;
        step();
        check("load_ffff", 32'(bus16.data), 32'hFFFF);
        check("load_ffff_wrap", 32'(bus16.wrap), 32'h0);
        bus16.load   = 1'b1;
        bus16.enable = 1'b1;
        step();
        check("wrap_data", 32'(bus16.data), 32'h0000);
        check("wrap_pulse", 32'(bus16.wrap), 32'h1);
        step();
        check("after_wrap_data", 32'(bus16.data), 32'h0001);
        check("after_wrap_pulse", 32'(bus16.wrap), 32'h0);

        // Loading zero from 0xFFFF with enable high must not flag a wrap.
        bus16.load    = 1'b0;
        bus16.address = 16'hFFFF;
        step();
        bus16.address = 16'h0000;
        step();
        check("load_zero_data", 32'(bus16.data), 32'h0);
        check("load_zero_wrap", 32'(bus16.wrap), 32'h0);

        // Mid-count reset at 100, released between edges.
        bus16.address = 16'd100;
        step();
        check("load_100", 32'(bus16.data), 32'd100);
        bus16.load = 1'b1;
        reset_n    = 1'b0;
        #1;
        check("midreset_data", 32'(bus16.data), 32'h0);
        check("midreset_wrap", 32'(bus16.wrap), 32'h0);
        #1 reset_n = 1'b1;
        step();
        check("resume_1", 32'(bus16.data), 32'd1);
        step();
        check("resume_2", 32'(bus16.data), 32'd2);

        // Narrow counter: load truncates the wide address, then wraps at 8 bits.
        bus16.enable = 1'b0;
        bus8.address = 16'h1234;
        bus8.load    = 1'b0;
        step();
        check("narrow_load_34", 32'(bus8.data), 32'h34);
        bus8.address = 16'h12FF;
        step();
        check("narrow_load_ff", 32'(bus8.data), 32'hFF);
        bus8.load   = 1'b1;
        bus8.enable = 1'b1;
        step();
        check("narrow_wrap_data", 32'(bus8.data), 32'h00);
        check("narrow_wrap_pulse", 32'(bus8.wrap), 32'h1);
        step();
        check("narrow_after_wrap", 32'(bus8.data), 32'h01);
        check("narrow_after_wrap_pulse", 32'(bus8.wrap), 32'h0);
        check("wide_held_2", 32'(bus16.data), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_counter_w_load
